serial_subtractor: RTL and testbench

Multi-cycle, bit-serial N-bit subtractor computing D = X - Y - Bin, with borrow-out and signed overflow. It is the inverse-operation counterpart to the team's combinational adder. It trades area for latency: one full-subtractor cell processes one bit per clock, LSB first. A Start/Busy/Done handshake lets lab top-levels drive it from switches or keys and show the held result on displays.

---
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor D = X - Y - Bin, LSB first
// One full-subtractor cell per clock; D/Bout/V only update on the completing edge.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         bin,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         v
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [N-1:0]   xr;
  logic [N-1:0]   yr;
  logic [N-2:0]   dr;
  logic           b;
  logic           xmsb;
  logic           ymsb;
  logic [CW-1:0]  count;

  logic           diff_bit;
  logic           borrow_next;
  logic [N-1:0]   dnew;

  assign diff_bit    = xr[0] ^ yr[0] ^ b;
  assign borrow_next = (~xr[0] & yr[0]) | (~(xr[0] ^ yr[0]) & b);
  assign dnew        = {diff_bit, dr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      dr    <= '0;
      b     <= 1'b0;
      xmsb  <= 1'b0;
      ymsb  <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= x;
            yr    <= y;
            b     <= bin;
            // Operand sign bits kept aside: xr/yr lose them while shifting.
            xmsb  <= x[N-1];
            ymsb  <= y[N-1];
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          xr    <= xr >> 1;
          yr    <= yr >> 1;
          dr    <= dnew[N-1:1];
          b     <= borrow_next;
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            d     <= dnew;
            bout  <= borrow_next;
            v     <= (xmsb != ymsb) && (dnew[N-1] != xmsb);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
// Drives on falling edges, samples on falling edges; N=4 and N=8 instances share clock/reset.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bin = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic       busy, done, bout, v;
  logic [3:0] d;

  logic       start8 = 1'b0;
  logic       bin8 = 1'b0;
  logic [7:0] x8 = '0;
  logic [7:0] y8 = '0;
  logic       busy8, done8, bout8, v8;
  logic [7:0] d8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .x(x), .y(y),
    .busy(busy), .done(done), .d(d), .bout(bout), .v(v)
  );

  serial_subtractor #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin(bin8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8), .v(v8)
  );

  // Leaves the bench at the falling edge right after the Start sample edge.
  task automatic launch(input logic [3:0] xa, input logic [3:0] ya, input logic ba);
    @(negedge clk);
    x = xa; y = ya; bin = ba; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts rising edges after the Start sample edge until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, d, bout, v} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b d=%0d bout=%b v=%b, want all 0", busy, done, d, bout, v);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    launch(4'd9, 4'd5, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_rise: got %b want 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL basic_latency: got %0d want 4", lat);
    end
    checks++;
    if (d !== 4'd4 || bout !== 1'b0 || v !== 1'b1) begin
      errors++; $display("FAIL basic_result: got d=%0d bout=%b v=%b want d=4 bout=0 v=1", d, bout, v);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_in_done: got %b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d !== 4'd4) begin
      errors++; $display("FAIL basic_after_done: got busy=%b done=%b d=%0d want 0 0 4", busy, done, d);
    end
  endtask

  task automatic test_signs;
    int lat;
    launch(4'd5, 4'd9, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 4 || d !== 4'd12 || bout !== 1'b1 || v !== 1'b1) begin
      errors++; $display("FAIL signs_5m9: got lat=%0d d=%0d bout=%b v=%b want 4 12 1 1", lat, d, bout, v);
    end
    launch(4'd0, 4'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (d !== 4'd12 || bout !== 1'b1 || v !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL signs_hold_midshift: got d=%0d bout=%b v=%b busy=%b want 12 1 1 1", d, bout, v, busy);
    end
    wait_done(lat);
    checks++;
    if (d !== 4'd15 || bout !== 1'b1 || v !== 1'b0) begin
      errors++; $display("FAIL signs_0m0m1: got d=%0d bout=%b v=%b want 15 1 0", d, bout, v);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    int pulses;
    launch(4'd7, 4'd2, 1'b0);
    @(negedge clk);
    x = 4'd1; y = 4'd1; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== 2 || d !== 4'd5 || bout !== 1'b0 || v !== 1'b0) begin
      errors++; $display("FAIL ignore_result: got lat=%0d d=%0d bout=%b v=%b want 2 5 0 0", lat, d, bout, v);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || d !== 4'd5 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_no_second_op: got pulses=%0d d=%0d busy=%b want 0 5 0", pulses, d, busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    launch(4'd9, 4'd5, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, d, bout, v} !== 8'h00) begin
      errors++; $display("FAIL reset_mid_async: got busy=%b done=%b d=%0d bout=%b v=%b want all 0", busy, done, d, bout, v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d !== 4'd0) begin
      errors++; $display("FAIL reset_mid_discarded: got busy=%b done=%b d=%0d want 0 0 0", busy, done, d);
    end
    launch(4'd3, 4'd3, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 4 || d !== 4'd0 || bout !== 1'b0 || v !== 1'b0) begin
      errors++; $display("FAIL reset_mid_relaunch: got lat=%0d d=%0d bout=%b v=%b want 4 0 0 0", lat, d, bout, v);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, last, pulses, glitch, bad_gap;
    @(negedge clk);
    x = 4'd6; y = 4'd2; bin = 1'b0; start = 1'b1;
    cyc = 0; last = 0; pulses = 0; glitch = 0; bad_gap = 0;
    while (pulses < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (pulses > 0 && (cyc - last) != 6) bad_gap++;
        last = cyc;
        pulses++;
      end
      if (pulses > 0 && d !== 4'd4) glitch++;
    end
    start = 1'b0;
    checks++;
    if (pulses !== 4 || bad_gap !== 0) begin
      errors++; $display("FAIL b2b_period: got pulses=%0d bad_gaps=%0d want 4 0", pulses, bad_gap);
    end
    checks++;
    if (glitch !== 0) begin
      errors++; $display("FAIL b2b_d_stable: got %0d cycles with d!=4 want 0", glitch);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || d !== 4'd4) begin
      errors++; $display("FAIL b2b_stop: got busy=%b d=%0d want 0 4", busy, d);
    end
  endtask

  task automatic test_n8;
    int lat;
    @(negedge clk);
    x8 = 8'd200; y8 = 8'd55; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL n8_latency: got %0d want 8", lat);
    end
    // -56 - 55 = -111 fits in 8-bit signed, so no overflow.
    checks++;
    if (d8 !== 8'd145 || bout8 !== 1'b0 || v8 !== 1'b0) begin
      errors++; $display("FAIL n8_result: got d=%0d bout=%b v=%b want 145 0 0", d8, bout8, v8);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    int lat, sx, sy, r;
    logic [3:0] ed;
    logic eb, ev;
    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        for (int bi = 0; bi < 2; bi++) begin
          ed = 4'((xi - yi - bi) & 15);
          eb = (xi < yi + bi);
          sx = (xi >= 8) ? xi - 16 : xi;
          sy = (yi >= 8) ? yi - 16 : yi;
          r  = sx - sy - bi;
          ev = (r < -8) || (r > 7);
          launch(4'(xi), 4'(yi), 1'(bi));
          wait_done(lat);
          checks++;
          if (lat !== 4 || d !== ed || bout !== eb || v !== ev) begin
            errors++;
            $display("FAIL sweep x=%0d y=%0d bin=%0d: got lat=%0d d=%0d bout=%b v=%b want 4 %0d %b %b",
                     xi, yi, bi, lat, d, bout, v, ed, eb, ev);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_n8();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
